irq_ctrl: RTL and testbench

Trap and interrupt controller sitting directly upstream of the microcode decoder. It arbitrates peripheral interrupt lines, MMU faults and SYSCALL traps, and drives the decoder's `irq_r`, `fault_r` and `cont_r` inputs. It holds the trap cause and interrupt vector base registers that the trap handler reads, and tracks handler entry and exit via the decoder's `SYSCALL`/`RETI` strobes and microcode state.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/sync_edge.sv | 32 +++
 rtl/irq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_irq_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the trap/interrupt path: trap cause codes, decoder
// microcode state numbers and the irq_ctrl FSM state encoding.
package cpu_pkg;

    // Trap cause codes; peripheral interrupts use their line index 0..7.
    localparam logic [3:0] CAUSE_SYSCALL  = 4'hC;
    localparam logic [3:0] CAUSE_FAULT    = 4'hE;
    localparam logic [3:0] CAUSE_DBLFAULT = 4'hF;

    // Decoder microcode states the controller observes.
    localparam logic [3:0] ST_TRAP  = 4'd0;
    localparam logic [3:0] ST_EXECM = 4'd8;

    // Controller FSM states.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PENDING = 2'd1,
        S_SERVICE = 2'd2,
        S_HALT    = 2'd3
    } irq_state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous level input, followed by a
// registered rising-edge detector producing a one-cycle pulse per press.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;
    logic pulse_reg;

    // Synchronise, remember the previous synchronised level, register the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
            pulse_reg <= 1'b0;
        end else begin
            sync1_reg <= din;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            pulse_reg <= sync2_reg & ~prev_reg;
        end
    end

    assign pulse = pulse_reg;

endmodule

// File: rtl/irq_ctrl.sv
// Trap and interrupt controller feeding the microcode decoder. Arbitrates
// faults, SYSCALL traps and masked peripheral interrupts, latches the trap
// cause, holds the vector base and tracks handler entry/exit.
module irq_ctrl
    import cpu_pkg::*;
#(
    parameter int          NIRQ       = 8,
    parameter logic [15:0] IVEC_RESET = 16'h0010
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NIRQ-1:0] irq_in,
    input  logic            fault_in,
    input  logic            syscall,
    input  logic            reti,
    input  logic [3:0]      dec_state,
    input  logic            ivec_load,
    input  logic            mask_load,
    input  logic [15:0]     wdata,
    input  logic            cont_in,
    output logic            irq_r,
    output logic            fault_r,
    output logic            cont_r,
    output logic [3:0]      cause,
    output logic [15:0]     ivec,
    output logic            in_trap,
    output logic            dbl_fault
);

    irq_state_t      state_reg, state_next;
    logic            irq_r_reg, irq_r_next;
    logic            fault_r_reg, fault_r_next;
    logic [3:0]      cause_reg, cause_next;
    logic            in_trap_reg, in_trap_next;
    logic            dbl_fault_reg, dbl_fault_next;
    logic [15:0]     ivec_reg;
    logic [NIRQ-1:0] mask_reg;
    logic [NIRQ-1:0] enabled;
    logic            irq_any;
    logic [3:0]      irq_idx;

    // Per-line enable: a request only counts when its mask bit is set.
    generate
        for (genvar gi = 0; gi < NIRQ; gi++) begin : g_enable
            assign enabled[gi] = irq_in[gi] & mask_reg[gi];
        end
    endgenerate

    // Priority encoder: lowest enabled line index wins.
    always_comb begin
        irq_idx = 4'd0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (enabled[i]) begin
                irq_idx = 4'(i);
            end
        end
    end

    assign irq_any = |enabled;

    // Vector base and mask registers, writable in any FSM state.
    always_ff @(posedge clk) begin
        if (reset) begin
            ivec_reg <= IVEC_RESET;
            mask_reg <= '0;
        end else begin
            if (ivec_load) begin
                ivec_reg <= wdata;
            end
            if (mask_load) begin
                mask_reg <= wdata[NIRQ-1:0];
            end
        end
    end

    // FSM state and registered decoder-facing outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            irq_r_reg     <= 1'b0;
            fault_r_reg   <= 1'b0;
            cause_reg     <= 4'd0;
            in_trap_reg   <= 1'b0;
            dbl_fault_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            irq_r_reg     <= irq_r_next;
            fault_r_reg   <= fault_r_next;
            cause_reg     <= cause_next;
            in_trap_reg   <= in_trap_next;
            dbl_fault_reg <= dbl_fault_next;
        end
    end

    // Next-state and output logic; fault beats syscall beats irq.
    always_comb begin
        state_next     = state_reg;
        irq_r_next     = irq_r_reg;
        fault_r_next   = 1'b0;
        cause_next     = cause_reg;
        dbl_fault_next = dbl_fault_reg;
        case (state_reg)
            S_IDLE: begin
                if (fault_in) begin
                    fault_r_next = 1'b1;
                    cause_next   = CAUSE_FAULT;
                    state_next   = S_SERVICE;
                end else if (syscall) begin
                    cause_next = CAUSE_SYSCALL;
                    state_next = S_SERVICE;
                end else if (irq_any) begin
                    cause_next = irq_idx;
                    irq_r_next = 1'b1;
                    state_next = S_PENDING;
                end
            end
            S_PENDING: begin
                // The latched cause stands even if the request line drops;
                // a pre-empted irq is re-raised by its level after RETI.
                if (fault_in) begin
                    fault_r_next = 1'b1;
                    cause_next   = CAUSE_FAULT;
                    irq_r_next   = 1'b0;
                    state_next   = S_SERVICE;
                end else if (dec_state == ST_TRAP) begin
                    irq_r_next = 1'b0;
                    state_next = S_SERVICE;
                end
            end
            S_SERVICE: begin
                if (fault_in) begin
                    fault_r_next   = 1'b1;
                    cause_next     = CAUSE_DBLFAULT;
                    dbl_fault_next = 1'b1;
                    state_next     = S_HALT;
                end else if (reti) begin
                    state_next = S_IDLE;
                end
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        in_trap_next = (state_next == S_SERVICE) || (state_next == S_HALT);
    end

    // Front-panel continue button, independent of the FSM (works in HALT).
    sync_edge u_cont_sync (
        .clk   (clk),
        .reset (reset),
        .din   (cont_in),
        .pulse (cont_r)
    );

    assign irq_r     = irq_r_reg;
    assign fault_r   = fault_r_reg;
    assign cause     = cause_reg;
    assign ivec      = ivec_reg;
    assign in_trap   = in_trap_reg;
    assign dbl_fault = dbl_fault_reg;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl: linear sequence of steps with
// hand-computed expectations, one line printed per check.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  irq_in;
    logic        fault_in;
    logic        syscall;
    logic        reti;
    logic [3:0]  dec_state;
    logic        ivec_load;
    logic        mask_load;
    logic [15:0] wdata;
    logic        cont_in;
    logic        irq_r;
    logic        fault_r;
    logic        cont_r;
    logic [3:0]  cause;
    logic [15:0] ivec;
    logic        in_trap;
    logic        dbl_fault;

    int errors = 0;
    int checks = 0;

    irq_ctrl #(
        .NIRQ       (8),
        .IVEC_RESET (16'h0010)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_in    (irq_in),
        .fault_in  (fault_in),
        .syscall   (syscall),
        .reti      (reti),
        .dec_state (dec_state),
        .ivec_load (ivec_load),
        .mask_load (mask_load),
        .wdata     (wdata),
        .cont_in   (cont_in),
        .irq_r     (irq_r),
        .fault_r   (fault_r),
        .cont_r    (cont_r),
        .cause     (cause),
        .ivec      (ivec),
        .in_trap   (in_trap),
        .dbl_fault (dbl_fault)
    );

    always #5 clk = ~clk;

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) begin
            $display("check %-22s observed=%0h expected=%0h ok", tag, obs, exp);
        end else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int pulses;
        int first_pulse;

        reset     = 1'b1;
        irq_in    = '0;
        fault_in  = 1'b0;
        syscall   = 1'b0;
        reti      = 1'b0;
        dec_state = 4'h8;
        ivec_load = 1'b0;
        mask_load = 1'b0;
        wdata     = '0;
        cont_in   = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_irq_r",     16'(irq_r), 16'h0);
        chk("rst_fault_r",   16'(fault_r), 16'h0);
        chk("rst_cont_r",    16'(cont_r), 16'h0);
        chk("rst_cause",     16'(cause), 16'h0);
        chk("rst_ivec",      ivec, 16'h0010);
        chk("rst_in_trap",   16'(in_trap), 16'h0);
        chk("rst_dbl_fault", 16'(dbl_fault), 16'h0);

        // Masked irq on lines 2 and 3: line 2 wins
        mask_load = 1'b1; wdata = 16'h000C;
        tick();
        mask_load = 1'b0; irq_in = 8'h0C;
        tick();
        chk("irq2_irq_r",   16'(irq_r), 16'h1);
        chk("irq2_cause",   16'(cause), 16'h2);
        chk("irq2_in_trap", 16'(in_trap), 16'h0);
        tick();
        chk("pend_hold_irq_r", 16'(irq_r), 16'h1);

        // ivec load during PENDING leaves the FSM alone
        ivec_load = 1'b1; wdata = 16'h0200;
        tick();
        ivec_load = 1'b0;
        chk("ivec_load",      ivec, 16'h0200);
        chk("ivec_pend_irq",  16'(irq_r), 16'h1);

        // Decoder reaches trap entry
        dec_state = 4'h0;
        tick();
        dec_state = 4'h8;
        chk("entry_irq_r",   16'(irq_r), 16'h0);
        chk("entry_in_trap", 16'(in_trap), 16'h1);
        chk("entry_cause",   16'(cause), 16'h2);

        // RETI back to IDLE
        irq_in = '0; reti = 1'b1;
        tick();
        reti = 1'b0;
        chk("reti_in_trap", 16'(in_trap), 16'h0);
        chk("reti_irq_r",   16'(irq_r), 16'h0);

        // fault + syscall + enabled irq3 together: fault wins
        fault_in = 1'b1; syscall = 1'b1; irq_in = 8'h08;
        tick();
        fault_in = 1'b0; syscall = 1'b0; irq_in = '0;
        chk("flt_fault_r", 16'(fault_r), 16'h1);
        chk("flt_cause",   16'(cause), 16'hE);
        chk("flt_in_trap", 16'(in_trap), 16'h1);
        chk("flt_irq_r",   16'(irq_r), 16'h0);
        tick();
        chk("flt_pulse_end", 16'(fault_r), 16'h0);
        chk("flt_service",   16'(in_trap), 16'h1);

        // Fault together with RETI in SERVICE: double fault
        fault_in = 1'b1; reti = 1'b1;
        tick();
        fault_in = 1'b0; reti = 1'b0;
        chk("dbl_cause",   16'(cause), 16'hF);
        chk("dbl_flag",    16'(dbl_fault), 16'h1);
        chk("dbl_fault_r", 16'(fault_r), 16'h1);
        chk("dbl_in_trap", 16'(in_trap), 16'h1);
        tick();
        chk("dbl_pulse_end", 16'(fault_r), 16'h0);
        reti = 1'b1;
        tick();
        reti = 1'b0;
        chk("halt_reti_in_trap", 16'(in_trap), 16'h1);
        chk("halt_reti_cause",   16'(cause), 16'hF);

        // Continue button held 10 cycles while halted: one pulse at cycle 3
        pulses = 0;
        first_pulse = -1;
        cont_in = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            if (i == 11) cont_in = 1'b0;
            tick();
            if (cont_r) begin
                pulses++;
                if (first_pulse < 0) first_pulse = i;
            end
        end
        chk("cont_pulses",  16'(pulses), 16'h1);
        chk("cont_latency", 16'(first_pulse), 16'h3);

        // Reset exits HALT and restores the vector base
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("halt_rst_ivec",    ivec, 16'h0010);
        chk("halt_rst_dbl",     16'(dbl_fault), 16'h0);
        chk("halt_rst_in_trap", 16'(in_trap), 16'h0);
        chk("halt_rst_cause",   16'(cause), 16'h0);

        // irq7 with mask cleared: nothing until the mask is loaded
        irq_in = 8'h80;
        tick();
        tick();
        chk("mask0_irq_r", 16'(irq_r), 16'h0);
        mask_load = 1'b1; wdata = 16'h0080;
        tick();
        mask_load = 1'b0;
        chk("mask_ld_irq_r_c1", 16'(irq_r), 16'h0);
        tick();
        chk("mask_ld_irq_r_c2", 16'(irq_r), 16'h1);
        chk("mask_ld_cause",    16'(cause), 16'h7);

        // Clearing the mask while PENDING does not retract irq_r
        mask_load = 1'b1; wdata = 16'h0000;
        tick();
        mask_load = 1'b0;
        chk("mask_clr_irq_r_a", 16'(irq_r), 16'h1);
        tick();
        chk("mask_clr_irq_r_b", 16'(irq_r), 16'h1);

        // Reset during PENDING
        reset = 1'b1;
        tick();
        reset = 1'b0; irq_in = '0;
        chk("pend_rst_irq_r",   16'(irq_r), 16'h0);
        chk("pend_rst_in_trap", 16'(in_trap), 16'h0);
        chk("pend_rst_fault_r", 16'(fault_r), 16'h0);
        chk("pend_rst_cont_r",  16'(cont_r), 16'h0);
        chk("pend_rst_cause",   16'(cause), 16'h0);
        chk("pend_rst_ivec",    ivec, 16'h0010);

        // SYSCALL, and no irq accepted while in SERVICE
        syscall = 1'b1;
        tick();
        syscall = 1'b0;
        chk("sys_cause",   16'(cause), 16'hC);
        chk("sys_in_trap", 16'(in_trap), 16'h1);
        chk("sys_irq_r",   16'(irq_r), 16'h0);
        mask_load = 1'b1; wdata = 16'h0006;
        tick();
        mask_load = 1'b0; irq_in = 8'h06;
        tick();
        tick();
        chk("svc_no_irq_r", 16'(irq_r), 16'h0);
        chk("svc_cause",    16'(cause), 16'hC);
        reti = 1'b1;
        tick();
        reti = 1'b0;
        chk("sys_reti_in_trap", 16'(in_trap), 16'h0);
        tick();
        chk("irq1_irq_r", 16'(irq_r), 16'h1);
        chk("irq1_cause", 16'(cause), 16'h1);

        // Fault pre-empts a pending irq
        fault_in = 1'b1;
        tick();
        fault_in = 1'b0;
        chk("pend_flt_fault_r", 16'(fault_r), 16'h1);
        chk("pend_flt_cause",   16'(cause), 16'hE);
        chk("pend_flt_irq_r",   16'(irq_r), 16'h0);
        chk("pend_flt_in_trap", 16'(in_trap), 16'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
